// File: rtl/ysyx_22041412_mem_arb_if.sv
// ----------------------------------------------------------------------------
// ysyx_22041412_mem_arb_if
//   Bundle of every handshake/bus signal around the IFU/LSU memory arbiter.
//   The arbiter connects through the "slave" modport. The environment side
//   (IFU, LSU and memory bridge, or a testbench) uses the "master" modport.
//
//   IFU side : if_valid_i, if_addr_i, if_flush_i  -> arbiter
//              if_ready_o, if_rdata_o[31:0]       <- arbiter
//   LSU side : ls_valid_i, ls_addr_i, ls_size_i   -> arbiter
//              ls_ready_o, ls_rdata_o             <- arbiter
//   Memory   : mem_valid_o, mem_addr_o, mem_size_o <- arbiter
//              mem_ready_i, mem_rdata_i            -> arbiter
// ----------------------------------------------------------------------------
interface ysyx_22041412_mem_arb_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_valid_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_ready_o;
    logic [31:0]       if_rdata_o;

    logic              ls_valid_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [7:0]        ls_size_i;
    logic              ls_ready_o;
    logic [DATA_W-1:0] ls_rdata_o;

    logic              mem_valid_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_size_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_valid_i, if_addr_i, if_flush_i,
        output if_ready_o, if_rdata_o,
        input  ls_valid_i, ls_addr_i, ls_size_i,
        output ls_ready_o, ls_rdata_o,
        output mem_valid_o, mem_addr_o, mem_size_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport master (
        output if_valid_i, if_addr_i, if_flush_i,
        input  if_ready_o, if_rdata_o,
        output ls_valid_i, ls_addr_i, ls_size_i,
        input  ls_ready_o, ls_rdata_o,
        input  mem_valid_o, mem_addr_o, mem_size_o,
        output mem_ready_i, mem_rdata_i
    );
endinterface

// File: rtl/ysyx_22041412_mem_arb.sv
// ----------------------------------------------------------------------------
// ysyx_22041412_mem_arb
//   Shares the single core memory read port between instruction fetch (IFU)
//   and the load unit (LSU). One request is granted at a time. The downstream
//   request is held stable until mem_ready_i. The read data is then registered
//   into the winner's rdata register, together with a one-cycle ready pulse.
//
//   Ports:
//     clk   - core clock, rising edge
//     rst_n - asynchronous, active-low reset
//     bus   - ysyx_22041412_mem_arb_if.slave (IFU, LSU and memory signals)
//
//   Build option:
//     YSYX_22041412_ARB_RR_EN - when defined, arbitration is round-robin using
//     a last-grant bit, which resets to IFU. When undefined, the LSU has fixed
//     priority over the IFU.
// ----------------------------------------------------------------------------
module ysyx_22041412_mem_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ysyx_22041412_mem_arb_if.slave         bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_LS = 2'd2
    } state_t;

    localparam logic [7:0] IF_SIZE = 8'b0000_0011;

    state_t            state_reg,     state_next;
    logic              mem_valid_reg, mem_valid_next;
    logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
    logic [7:0]        mem_size_reg,  mem_size_next;
    logic              if_ready_reg,  if_ready_next;
    logic [31:0]       if_rdata_reg,  if_rdata_next;
    logic              ls_ready_reg,  ls_ready_next;
    logic [DATA_W-1:0] ls_rdata_reg,  ls_rdata_next;
    logic              drop_reg,      drop_next;
`ifdef YSYX_22041412_ARB_RR_EN
    logic              last_ls_reg,   last_ls_next;   // 1: last grant went to LSU
`endif

    // A requester is masked in its own ready cycle, because its valid may
    // still be high from the request that was just answered.
    logic if_elig, ls_elig, pick_ls, pick_if, drop_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mem_valid_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_size_reg  <= '0;
            if_ready_reg  <= 1'b0;
            if_rdata_reg  <= '0;
            ls_ready_reg  <= 1'b0;
            ls_rdata_reg  <= '0;
            drop_reg      <= 1'b0;
`ifdef YSYX_22041412_ARB_RR_EN
            last_ls_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            mem_valid_reg <= mem_valid_next;
            mem_addr_reg  <= mem_addr_next;
            mem_size_reg  <= mem_size_next;
            if_ready_reg  <= if_ready_next;
            if_rdata_reg  <= if_rdata_next;
            ls_ready_reg  <= ls_ready_next;
            ls_rdata_reg  <= ls_rdata_next;
            drop_reg      <= drop_next;
`ifdef YSYX_22041412_ARB_RR_EN
            last_ls_reg   <= last_ls_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        mem_valid_next = mem_valid_reg;
        mem_addr_next  = mem_addr_reg;
        mem_size_next  = mem_size_reg;
        if_ready_next  = 1'b0;
        if_rdata_next  = if_rdata_reg;
        ls_ready_next  = 1'b0;
        ls_rdata_next  = ls_rdata_reg;
        drop_next      = drop_reg;
`ifdef YSYX_22041412_ARB_RR_EN
        last_ls_next   = last_ls_reg;
`endif

        if_elig = bus.if_valid_i & ~if_ready_reg;
        ls_elig = bus.ls_valid_i & ~ls_ready_reg;
`ifdef YSYX_22041412_ARB_RR_EN
        // On a tie, the master that was not granted last wins.
        pick_ls = ls_elig & (~if_elig | ~last_ls_reg);
`else
        pick_ls = ls_elig;
`endif
        pick_if = if_elig & ~pick_ls;
        // A flush in the completion cycle still drops the response.
        drop_now = drop_reg | bus.if_flush_i;

        case (state_reg)
            IDLE: begin
                if (pick_ls) begin
                    state_next     = GNT_LS;
                    mem_valid_next = 1'b1;
                    mem_addr_next  = bus.ls_addr_i;
                    mem_size_next  = bus.ls_size_i;
`ifdef YSYX_22041412_ARB_RR_EN
                    last_ls_next   = 1'b1;
`endif
                end else if (pick_if) begin
                    state_next     = GNT_IF;
                    mem_valid_next = 1'b1;
                    mem_addr_next  = bus.if_addr_i;
                    mem_size_next  = IF_SIZE;
`ifdef YSYX_22041412_ARB_RR_EN
                    last_ls_next   = 1'b0;
`endif
                end
            end
            GNT_IF: begin
                drop_next = drop_now;
                if (mem_valid_reg && bus.mem_ready_i) begin
                    if (!drop_now) begin
                        if_ready_next = 1'b1;
                        if_rdata_next = bus.mem_rdata_i[31:0];
                    end
                    mem_valid_next = 1'b0;
                    drop_next      = 1'b0;
                    state_next     = IDLE;
                end
            end
            GNT_LS: begin
                if (mem_valid_reg && bus.mem_ready_i) begin
                    ls_ready_next  = 1'b1;
                    ls_rdata_next  = bus.mem_rdata_i;
                    mem_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                mem_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.mem_valid_o = mem_valid_reg;
    assign bus.mem_addr_o  = mem_addr_reg;
    assign bus.mem_size_o  = mem_size_reg;
    assign bus.if_ready_o  = if_ready_reg;
    assign bus.if_rdata_o  = if_rdata_reg;
    assign bus.ls_ready_o  = ls_ready_reg;
    assign bus.ls_rdata_o  = ls_rdata_reg;
endmodule

// File: tb/tb_ysyx_22041412_mem_arb.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041412_mem_arb
//   Directed test of the IFU/LSU memory arbiter. The scenarios are: a single
//   fetch, simultaneous requests, wait states, flush handling, the stale-request
//   mask and reset in the middle of a transaction.
// ----------------------------------------------------------------------------
module tb_ysyx_22041412_mem_arb;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_22041412_mem_arb_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    ysyx_22041412_mem_arb #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.if_valid_i  = 1'b0;
        bus.if_addr_i   = '0;
        bus.if_flush_i  = 1'b0;
        bus.ls_valid_i  = 1'b0;
        bus.ls_addr_i   = '0;
        bus.ls_size_i   = '0;
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;

        // Reset state
        step(); step();
        chk("rst_mem_valid", {63'd0, bus.mem_valid_o}, 64'd0);
        chk("rst_mem_addr",  bus.mem_addr_o, 64'd0);
        chk("rst_mem_size",  {56'd0, bus.mem_size_o}, 64'd0);
        chk("rst_if_ready",  {63'd0, bus.if_ready_o}, 64'd0);
        chk("rst_ls_ready",  {63'd0, bus.ls_ready_o}, 64'd0);
        chk("rst_if_rdata",  {32'd0, bus.if_rdata_o}, 64'd0);
        chk("rst_ls_rdata",  bus.ls_rdata_o, 64'd0);
        rst_n = 1'b1;
        step();
        $display("txn reset: outputs checked zero");

        // Single IFU fetch
        bus.if_valid_i = 1'b1;
        bus.if_addr_i  = 64'h8000_0000;
        step();
        chk("f1_mem_valid", {63'd0, bus.mem_valid_o}, 64'd1);
        chk("f1_mem_addr",  bus.mem_addr_o, 64'h8000_0000);
        chk("f1_mem_size",  {56'd0, bus.mem_size_o}, 64'h03);
        chk("f1_if_ready0", {63'd0, bus.if_ready_o}, 64'd0);
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 64'h0000_0000_0010_0513;
        step();
        chk("f1_if_ready",  {63'd0, bus.if_ready_o}, 64'd1);
        chk("f1_if_rdata",  {32'd0, bus.if_rdata_o}, 64'h0010_0513);
        chk("f1_mem_clr",   {63'd0, bus.mem_valid_o}, 64'd0);
        // Stale-request mask: valid stays high through the ready cycle.
        bus.mem_ready_i = 1'b0;
        step();
        chk("stale_no_gnt", {63'd0, bus.mem_valid_o}, 64'd0);
        chk("stale_pulse1", {63'd0, bus.if_ready_o}, 64'd0);
        bus.if_valid_i = 1'b0;
        step();
        $display("txn ifu fetch addr=80000000 rdata=%h", bus.if_rdata_o);

        // Simultaneous requests: LSU first, IFU after one idle cycle
        bus.if_valid_i = 1'b1;
        bus.if_addr_i  = 64'h8000_0004;
        bus.ls_valid_i = 1'b1;
        bus.ls_addr_i  = 64'h8000_1000;
        bus.ls_size_i  = 8'h03;
        step();
        chk("sim_ls_addr",  bus.mem_addr_o, 64'h8000_1000);
        chk("sim_ls_size",  {56'd0, bus.mem_size_o}, 64'h03);
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 64'hDEAD_BEEF_1234_5678;
        step();
        chk("sim_ls_ready", {63'd0, bus.ls_ready_o}, 64'd1);
        chk("sim_ls_rdata", bus.ls_rdata_o, 64'hDEAD_BEEF_1234_5678);
        chk("sim_if_quiet", {63'd0, bus.if_ready_o}, 64'd0);
        chk("sim_if_hold",  {32'd0, bus.if_rdata_o}, 64'h0010_0513);
        chk("sim_idle",     {63'd0, bus.mem_valid_o}, 64'd0);
        bus.mem_ready_i = 1'b0;
        bus.ls_valid_i  = 1'b0;
        step();
        chk("sim_if_gnt",   {63'd0, bus.mem_valid_o}, 64'd1);
        chk("sim_if_addr",  bus.mem_addr_o, 64'h8000_0004);
        chk("sim_if_size",  {56'd0, bus.mem_size_o}, 64'h03);
        chk("sim_ls_pulse", {63'd0, bus.ls_ready_o}, 64'd0);
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 64'hFFFF_FFFF_0000_0013;
        step();
        chk("sim_if_ready", {63'd0, bus.if_ready_o}, 64'd1);
        chk("sim_if_rdata", {32'd0, bus.if_rdata_o}, 64'h0000_0013);
        chk("sim_ls_keep",  bus.ls_rdata_o, 64'hDEAD_BEEF_1234_5678);
        bus.if_valid_i  = 1'b0;
        bus.mem_ready_i = 1'b0;
        step();
        chk("sim_if_pulse", {63'd0, bus.if_ready_o}, 64'd0);
        $display("txn simultaneous: ls then if served");

        // LSU with five wait states
        bus.ls_valid_i = 1'b1;
        bus.ls_addr_i  = 64'h8000_2000;
        bus.ls_size_i  = 8'h02;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("ws_valid", {63'd0, bus.mem_valid_o}, 64'd1);
            chk("ws_addr",  bus.mem_addr_o, 64'h8000_2000);
            chk("ws_size",  {56'd0, bus.mem_size_o}, 64'h02);
            chk("ws_noready", {63'd0, bus.ls_ready_o}, 64'd0);
            step();
        end
        chk("ws_valid5", {63'd0, bus.mem_valid_o}, 64'd1);
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 64'h0123_4567_89AB_CDEF;
        step();
        chk("ws_ready",  {63'd0, bus.ls_ready_o}, 64'd1);
        chk("ws_rdata",  bus.ls_rdata_o, 64'h0123_4567_89AB_CDEF);
        bus.ls_valid_i = 1'b0;
        // mem_ready_i held high into IDLE must be ignored
        step();
        chk("ws_one_pulse", {63'd0, bus.ls_ready_o}, 64'd0);
        chk("idle_rdy_ign", {63'd0, bus.mem_valid_o}, 64'd0);
        step();
        chk("idle_rdy_ls",  {63'd0, bus.ls_ready_o}, 64'd0);
        chk("idle_rdy_if",  {63'd0, bus.if_ready_o}, 64'd0);
        bus.mem_ready_i = 1'b0;
        $display("txn lsu wait states: rdata=%h", bus.ls_rdata_o);

        // Flush during fetch: pulse in the second GNT_IF cycle
        bus.if_valid_i = 1'b1;
        bus.if_addr_i  = 64'h8000_0008;
        step();
        chk("fl_gnt", {63'd0, bus.mem_valid_o}, 64'd1);
        step();
        bus.if_flush_i = 1'b1;
        step();
        bus.if_flush_i  = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 64'h0000_0000_AAAA_5555;
        bus.if_addr_i   = 64'h8000_0100;
        step();
        chk("fl_no_ready", {63'd0, bus.if_ready_o}, 64'd0);
        chk("fl_rdata",    {32'd0, bus.if_rdata_o}, 64'h0000_0013);
        chk("fl_done",     {63'd0, bus.mem_valid_o}, 64'd0);
        bus.mem_ready_i = 1'b0;
        step();
        chk("fl_next_gnt",  {63'd0, bus.mem_valid_o}, 64'd1);
        chk("fl_next_addr", bus.mem_addr_o, 64'h8000_0100);
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 64'h0000_0000_0000_0073;
        step();
        chk("fl_next_rdy", {63'd0, bus.if_ready_o}, 64'd1);
        chk("fl_next_dat", {32'd0, bus.if_rdata_o}, 64'h0000_0073);
        bus.if_valid_i  = 1'b0;
        bus.mem_ready_i = 1'b0;
        step();
        // Flush coinciding with completion drops the response
        bus.if_valid_i = 1'b1;
        bus.if_addr_i  = 64'h8000_0200;
        step();
        bus.if_flush_i  = 1'b1;
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 64'h0000_0000_0000_ABCD;
        bus.if_valid_i  = 1'b0;
        step();
        chk("flc_no_ready", {63'd0, bus.if_ready_o}, 64'd0);
        chk("flc_rdata",    {32'd0, bus.if_rdata_o}, 64'h0000_0073);
        chk("flc_done",     {63'd0, bus.mem_valid_o}, 64'd0);
        bus.if_flush_i  = 1'b0;
        bus.mem_ready_i = 1'b0;
        step();
        $display("txn flush: responses dropped, refetch ok");

        // Reset in the middle of an LSU transaction
        bus.ls_valid_i = 1'b1;
        bus.ls_addr_i  = 64'h8000_3000;
        bus.ls_size_i  = 8'h07;
        step();
        chk("rm_gnt", {63'd0, bus.mem_valid_o}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_valid",    {63'd0, bus.mem_valid_o}, 64'd0);
        chk("rm_addr",     bus.mem_addr_o, 64'd0);
        chk("rm_size",     {56'd0, bus.mem_size_o}, 64'd0);
        chk("rm_ls_rdata", bus.ls_rdata_o, 64'd0);
        chk("rm_if_rdata", {32'd0, bus.if_rdata_o}, 64'd0);
        bus.ls_valid_i  = 1'b0;
        bus.mem_ready_i = 1'b1;
        step();
        chk("rm_no_ready", {63'd0, bus.ls_ready_o}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("rm_no_ready2", {63'd0, bus.ls_ready_o}, 64'd0);
        chk("rm_idle",      {63'd0, bus.mem_valid_o}, 64'd0);
        bus.mem_ready_i = 1'b0;
        $display("txn reset mid-transaction: outputs cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
